pipe_stage_buf: RTL

Parametrised, handshaked pipeline stage register that supersedes the fixed-field ID/EX style registers between core stages. It carries one control bundle and one data bundle per beat, with valid/ready flow control, whole-stage flush and squash of the incoming beat. Killed or empty slots present a configurable NOP control word. An optional two-entry skid buffer registers the upstream ready path.

---
 rtl/pipe_stage_buf.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: handshaked pipeline stage register with flush, kill and a NOP control word when empty.
// PIPE_STAGE_SKID_EN selects the two-entry skid buffer with a registered in_ready.
module pipe_stage_buf #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 154,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              kill_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic take, emit;
  assign take = in_valid & in_ready & ~kill_in & ~flush;
  assign emit = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q;
  logic rdy_q;
  logic [CTRL_W-1:0] ctrl_q, sk_ctrl_q;
  logic [DATA_W-1:0] data_q, sk_data_q;
  assign in_ready  = rdy_q;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  // rdy_q tracks "not TWO" as a flop so in_ready has no path from out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      rdy_q     <= 1'b1;
      ctrl_q    <= CTRL_NOP;
      sk_ctrl_q <= CTRL_NOP;
      data_q    <= '0;
      sk_data_q <= '0;
    end else if (flush) begin
      state_q   <= EMPTY;
      rdy_q     <= 1'b1;
      ctrl_q    <= CTRL_NOP;
      sk_ctrl_q <= CTRL_NOP;
    end else begin
      case (state_q)
        EMPTY: if (take) begin
          state_q <= ONE;
          ctrl_q  <= in_ctrl;
          data_q  <= in_data;
        end
        ONE: if (take && !emit) begin
          state_q   <= TWO;
          rdy_q     <= 1'b0;
          sk_ctrl_q <= in_ctrl;
          sk_data_q <= in_data;
        end else if (take) begin
          ctrl_q <= in_ctrl;
          data_q <= in_data;
        end else if (emit) begin
          state_q <= EMPTY;
          ctrl_q  <= CTRL_NOP;
        end
        TWO: if (emit) begin
          state_q   <= ONE;
          rdy_q     <= 1'b1;
          ctrl_q    <= sk_ctrl_q;
          data_q    <= sk_data_q;
          sk_ctrl_q <= CTRL_NOP;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
`else
  logic valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign occupancy = {1'b0, valid_q};
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_NOP;
      end else if (take) begin
        valid_q <= 1'b1;
        ctrl_q  <= in_ctrl;
      end else if (emit) begin
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_NOP;
      end
      if (take) data_q <= in_data;
    end
  end
`endif
endmodule
